// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART data FIFO.
// Covers the default widths, the read-mode enum and the pointer-width helper.
package uart_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic {
    MODE_REG  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// Bus between the APB register block (master) and the UART data FIFO (slave).
// A write or pop is a single-cycle request. The FIFO accepts it unless full/empty
// blocks it, and it has no ready back-pressure: a refused request only raises ovf/udf.
interface uart_fifo_if
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   fifo_fill_cnt;
  logic [ADDR_WIDTH:0]   rts_hi_th;
  logic [ADDR_WIDTH:0]   rts_lo_th;
  logic                  flow_ctrl_rts_n;
  logic [ADDR_WIDTH:0]   water_mark_th;
  logic                  water_mark_status;
  logic                  ovf;
  logic                  udf;
  logic                  err_clr;

  modport master (
    output flush, wr_en, wr_data, rd_en, rts_hi_th, rts_lo_th, water_mark_th, err_clr,
    input  rd_data, rd_valid, full, empty, fifo_fill_cnt, flow_ctrl_rts_n,
           water_mark_status, ovf, udf
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, rts_hi_th, rts_lo_th, water_mark_th, err_clr,
    output rd_data, rd_valid, full, empty, fifo_fill_cnt, flow_ctrl_rts_n,
           water_mark_status, ovf, udf
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Storage is intentionally left unreset.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Single-clock UART data FIFO controller. It holds the pointers, occupancy,
// sticky error flags, RTS hysteresis and watermark, and supports registered or FWFT reads.
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FWFT       = 0
) (
  input logic       clk,
  input logic       rst_n,
  uart_fifo_if.slave bus
);

  localparam int         PW    = ptr_width(ADDR_WIDTH);
  localparam fifo_mode_e MODE  = (FWFT != 0) ? MODE_FWFT : MODE_REG;
  localparam logic [PW-1:0] DEPTH_CNT = PW'(2**ADDR_WIDTH);

  typedef logic [PW-1:0] ptr_t;

  ptr_t                  wr_ptr, rd_ptr, cnt, cnt_nxt;
  logic                  empty_r, full_r, ovf_r, udf_r, rts_r, wm_r;
  logic                  rd_acc, wr_acc, do_rd, do_wr;
  logic [DATA_WIDTH-1:0] head;

  always_comb begin
    rd_acc  = bus.rd_en && !empty_r;
    wr_acc  = bus.wr_en && (!full_r || rd_acc);
    do_rd   = rd_acc && !bus.flush;
    do_wr   = wr_acc && !bus.flush;
    cnt_nxt = cnt;
    if (bus.flush)            cnt_nxt = '0;
    else if (do_wr && !do_rd) cnt_nxt = cnt + ptr_t'(1);
    else if (do_rd && !do_wr) cnt_nxt = cnt - ptr_t'(1);
  end

  uart_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
      rts_r   <= 1'b0;
      wm_r    <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + ptr_t'(1);
        if (do_rd) rd_ptr <= rd_ptr + ptr_t'(1);
      end
      cnt     <= cnt_nxt;
      empty_r <= (cnt_nxt == '0);
      full_r  <= (cnt_nxt == DEPTH_CNT);
      // A fresh error outranks err_clr in the same cycle; flush suppresses new errors.
      ovf_r   <= (!bus.flush && bus.wr_en && !wr_acc) || (ovf_r && !bus.err_clr);
      udf_r   <= (!bus.flush && bus.rd_en && empty_r) || (udf_r && !bus.err_clr);
      if (cnt_nxt >= bus.rts_hi_th)      rts_r <= 1'b1;
      else if (cnt_nxt <= bus.rts_lo_th) rts_r <= 1'b0;
      wm_r    <= (cnt_nxt >= bus.water_mark_th);
    end
  end

  if (MODE == MODE_FWFT) begin : g_fwft
    // Head word is gated to zero while empty so the unreset array never leaks out.
    assign bus.rd_data  = empty_r ? '0 : head;
    assign bus.rd_valid = !empty_r;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_r  <= '0;
        rd_valid_r <= 1'b0;
      end else begin
        rd_valid_r <= do_rd;
        if (do_rd) rd_data_r <= head;
      end
    end

    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
  end

  assign bus.full              = full_r;
  assign bus.empty             = empty_r;
  assign bus.fifo_fill_cnt     = cnt;
  assign bus.flow_ctrl_rts_n   = rts_r;
  assign bus.water_mark_status = wm_r;
  assign bus.ovf               = ovf_r;
  assign bus.udf               = udf_r;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: registered-read and FWFT instances share one stimulus
// stream and are checked against a queue-based reference model.
module tb_uart_fifo_ctrl;
  import uart_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 0, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   hi_th = 5'd12, lo_th = 5'd4, wm_th = 5'd8;

  uart_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  uart_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  assign if0.flush = flush;   assign if1.flush = flush;
  assign if0.wr_en = wr_en;   assign if1.wr_en = wr_en;
  assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
  assign if0.rd_en = rd_en;   assign if1.rd_en = rd_en;
  assign if0.err_clr = err_clr; assign if1.err_clr = err_clr;
  assign if0.rts_hi_th = hi_th; assign if1.rts_hi_th = hi_th;
  assign if0.rts_lo_th = lo_th; assign if1.rts_lo_th = lo_th;
  assign if0.water_mark_th = wm_th; assign if1.water_mark_th = wm_th;

  uart_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  uart_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  bit m_ovf, m_udf, m_rts, m_wm, m_rv;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    mq.delete();
    exp_q.delete();
    m_ovf = 0; m_udf = 0; m_rts = 0; m_wm = 0; m_rv = 0;
  end

  always @(posedge clk) begin
    bit ra, wa, so, su;
    int n, c;
    if (rst_n) begin
      n = mq.size();
      so = 0; su = 0; m_rv = 0;
      if (flush) begin
        mq.delete();
      end else begin
        ra = rd_en && (n > 0);
        wa = wr_en && ((n < DEPTH) || ra);
        so = wr_en && !wa;
        su = rd_en && (n == 0);
        if (ra) begin
          exp_q.push_back(mq.pop_front());
          m_rv = 1;
        end
        if (wa) mq.push_back(wr_data);
      end
      m_ovf = so || (m_ovf && !err_clr);
      m_udf = su || (m_udf && !err_clr);
      c = mq.size();
      if (c >= int'(hi_th))      m_rts = 1;
      else if (c <= int'(lo_th)) m_rts = 0;
      m_wm = (c >= int'(wm_th));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk_status(input string tag, input logic [AW:0] cnt, input logic e,
                            input logic f, input logic r, input logic w,
                            input logic o, input logic u);
    chk({tag, "_cnt"},   32'(cnt), 32'(mq.size()));
    chk({tag, "_empty"}, 32'(e),   32'(mq.size() == 0));
    chk({tag, "_full"},  32'(f),   32'(mq.size() == DEPTH));
    chk({tag, "_rts"},   32'(r),   32'(m_rts));
    chk({tag, "_wm"},    32'(w),   32'(m_wm));
    chk({tag, "_ovf"},   32'(o),   32'(m_ovf));
    chk({tag, "_udf"},   32'(u),   32'(m_udf));
  endtask

  always @(posedge clk) begin
    logic [DW-1:0] h;
    #1;
    chk_status("reg", if0.fifo_fill_cnt, if0.empty, if0.full, if0.flow_ctrl_rts_n,
               if0.water_mark_status, if0.ovf, if0.udf);
    chk_status("fwft", if1.fifo_fill_cnt, if1.empty, if1.full, if1.flow_ctrl_rts_n,
               if1.water_mark_status, if1.ovf, if1.udf);
    chk("reg_rd_valid", 32'(if0.rd_valid), 32'(m_rv));
    if (if0.rd_valid) begin
      if (exp_q.size() == 0) chk("reg_rd_unexpected", 32'(1), 32'(0));
      else                   chk("reg_rd_data", 32'(if0.rd_data), 32'(exp_q.pop_front()));
    end
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("fwft_rd_valid", 32'(if1.rd_valid), 32'(mq.size() != 0));
    chk("fwft_rd_data", 32'(if1.rd_data), 32'(h));
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit f = 0, input bit ec = 0);
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = ec;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rd_data", 32'(if0.rd_data), 32'(0));
    chk("rst_rts", 32'(if0.flow_ctrl_rts_n), 32'(0));
    rst_n = 1'b1;
    idle(2);

    // Fill 1..16, overflow attempt, drain with one extra read.
    for (int i = 1; i <= DEPTH; i++) cyc(1, DW'(i), 0);
    cyc(1, 8'hAA, 0);
    chk("full_after_16", 32'(if0.full), 32'(1));
    idle(1);
    chk("ovf_after_AA", 32'(if0.ovf), 32'(1));
    for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1);
    cyc(0, '0, 1);
    idle(2);
    chk("empty_after_drain", 32'(if0.empty), 32'(1));
    cyc(0, '0, 0, 0, 1);
    idle(1);

    // Full FIFO with simultaneous write and read.
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'(8'h40 + i), 0);
    cyc(1, 8'hC1, 1);
    cyc(1, 8'hC2, 1);
    idle(1);
    chk("full_wr_rd_cnt", 32'(if0.fifo_fill_cnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1);
    idle(2);

    // FWFT single word into empty, pop, then underflow.
    cyc(1, 8'h5A, 0);
    idle(1);
    chk("fwft_5a", 32'(if1.rd_data), 32'(8'h5A));
    cyc(0, '0, 1);
    cyc(0, '0, 1);
    idle(1);

    // Watermark at count 9, then flush with wr_en, then err_clr.
    for (int i = 0; i < 9; i++) cyc(1, DW'(i + 8'h90), 0);
    cyc(1, 8'hEE, 0, 1);
    idle(1);
    chk("flush_cnt", 32'(if0.fifo_fill_cnt), 32'(0));
    cyc(0, '0, 0, 0, 1);
    idle(1);

    // Asynchronous reset mid-burst at count 7.
    for (int i = 0; i < 7; i++) cyc(1, DW'(i + 8'h70), 0);
    @(negedge clk);
    wr_en = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(if0.fifo_fill_cnt), 32'(0));
    chk("arst_empty", 32'(if1.empty), 32'(1));
    chk("arst_rd_valid", 32'(if1.rd_valid), 32'(0));
    idle(2);
    rst_n = 1'b1;
    cyc(1, 8'h3C, 0);
    cyc(0, '0, 1);
    idle(2);

    // Randomised phases alternating write-heavy and read-heavy traffic.
    for (int p = 0; p < 8; p++) begin
      int wp;
      wp = (p % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 99) == 0) begin
          hi_th = AW'($urandom_range(0, 17));
          lo_th = AW'($urandom_range(0, 17));
          wm_th = AW'($urandom_range(0, 17));
        end
        cyc($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < (100 - wp),
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
      end
    end

    // Drain and confirm every popped word was delivered.
    for (int i = 0; i < DEPTH + 4; i++) cyc(0, '0, 1);
    idle(3);
    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Parametrised single-clock UART data FIFO; next generation of the UART buffering block for same-domain TX/RX paths.
Adds selectable first-word-fall-through (FWFT) mode, RTS flow control with hysteresis, a registered watermark, sticky overflow/underflow flags and a synchronous flush.
Sits between the APB register interface and the UART shifter; all status outputs feed the UART status register.

Parameters:
DATA_WIDTH, 8, data word width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH; must be >= 2
FWFT, 0, 0 = registered-read mode; 1 = first-word-fall-through mode

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush pulse
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read/pop request
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data valid
full  out  1  count == DEPTH
empty  out  1  count == 0
fifo_fill_cnt  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
rts_hi_th  in  ADDR_WIDTH+1  rts_n rises at fill >= this value
rts_lo_th  in  ADDR_WIDTH+1  rts_n falls at fill <= this value
flow_ctrl_rts_n  out  1  0 = peer may send, 1 = stop
water_mark_th  in  ADDR_WIDTH+1  watermark threshold
water_mark_status  out  1  fill >= water_mark_th
ovf  out  1  sticky overflow flag
udf  out  1  sticky underflow flag
err_clr  in  1  clears ovf/udf

Behaviour:
- Reset (rst_n low, async): pointers = 0, fifo_fill_cnt = 0, empty = 1, full = 0, rd_valid = 0, rd_data = 0, flow_ctrl_rts_n = 0, water_mark_status = 0 (1 if water_mark_th == 0 after first clock), ovf = udf = 0. Memory array is not reset.
- Pointers: ADDR_WIDTH+1 bits, binary, wrap modulo 2*DEPTH. fifo_fill_cnt is a registered up/down counter and must always equal wr_ptr - rd_ptr.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). A write to a full FIFO with a simultaneous accepted read succeeds; count is unchanged.
- Write on an empty FIFO with simultaneous rd_en: write accepted, read rejected, udf set.
- Count update per cycle: +1 for wr_acc only, -1 for rd_acc only, unchanged for both or neither. full and empty are registered from the next count.
- FWFT = 0 mode:
  - On rd_acc, rd_data is loaded with the head word and rd_valid = 1 on the next cycle (1-cycle latency).
  - rd_valid is a 1-cycle pulse; rd_data holds its value until the next accepted read.
- FWFT = 1 mode:
  - rd_data always shows the head word; rd_valid = !empty. Output is combinational from the registered pointer.
  - rd_acc pops the entry; the next word is visible the following cycle.
  - A word written into an empty FIFO is visible one cycle after the write.
- Overflow: wr_en && !wr_acc sets ovf. Underflow: rd_en && empty sets udf.
- Flag clear: err_clr clears both flags. A new error in the same cycle as err_clr wins (flag stays 1).
- Flush:
  - Synchronous; takes priority over wr_en/rd_en in the same cycle (both ignored, no flags set).
  - Next cycle: pointers = 0, count = 0, empty = 1, rd_valid = 0.
  - ovf/udf are not affected by flush.
- Flow control (registered, evaluated on next count):
  - flow_ctrl_rts_n sets to 1 when count >= rts_hi_th.
  - It clears to 0 when count <= rts_lo_th; otherwise it holds.
  - Required: rts_lo_th < rts_hi_th. If this is violated, set has priority.
- Watermark: water_mark_status is registered, = (next count >= water_mark_th).
- Threshold changes take effect on the next clock with no other side effects.
- Timing: all outputs are registered except rd_data in FWFT mode. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package uart_fifo_pkg: default DATA_WIDTH/ADDR_WIDTH constants, a FWFT mode enum (MODE_REG = 0, MODE_FWFT = 1), and a ptr_t width helper.
- One sub-module, uart_fifo_mem: simple dual-port register array, one synchronous write port and one asynchronous read port, parametrised by DATA_WIDTH/ADDR_WIDTH.
- Pointer, count, flag and flow-control logic stay in uart_fifo_ctrl.

Test Plan:
1. FWFT = 0, DEPTH = 16: write 0x01..0x10, then a 17th write 0xAA -> full = 1 after write 16, ovf = 1, 0xAA dropped. Reads return 0x01..0x10 with rd_valid one cycle after each rd_en, then empty = 1.
2. Full FIFO, wr_en and rd_en in the same cycle -> count stays 16, ovf stays 0, head is read, and the new word appears last in the read order.
3. rts_hi_th = 12, rts_lo_th = 4:
   - Fill to 11 -> rts_n = 0; the 12th write -> rts_n = 1 next cycle.
   - Drain to 5 -> rts_n still 1; reaching 4 -> rts_n = 0.
4. FWFT = 1: write 0x5A into an empty FIFO -> rd_data = 0x5A and rd_valid = 1 one cycle later. rd_en -> empty = 1 and rd_valid = 0 next cycle. A further rd_en sets udf.
5. Count 9, water_mark_th = 8 -> water_mark_status = 1. Assert flush together with wr_en -> next cycle count = 0, empty = 1, water_mark_status = 0, ovf/udf unchanged. err_clr then clears the flags.
6. Assert rst_n low mid-burst at count 7 -> all outputs reach reset values immediately (asynchronously). After release, a write/read of 0x3C round-trips correctly.
